hdlc_rx_desc_ctrl: RTL and testbench
====================================

// Module: hdlc_rx_desc_ctrl
// PURPOSE
//  Downstream of hdlcrev, in the clk_100m domain. Synchronises the receiver end-of-frame interrupt and captures the frame length (final rama).
//  Queues one descriptor per frame in a small FIFO and pulses a DSP interrupt (GPIO).
//  Exposes status, descriptor and control registers on the EMIF register bus, so the DSP knows how many bytes of hdlc_rx_ram to read and can pop each frame.
// PARAMETERS
//  REG_BASE     24'h000100  EMIF word address of register window (4 regs, BASE+0..BASE+3)
//  FIFO_DEPTH   4           descriptor FIFO entries; power of 2, 2..16
//  IRQ_WIDTH    50          DSP interrupt pulse length, clk_100m cycles (1..255)
//  TIMEOUT_CYC  100000      un-acked re-interrupt period (only with HDLC_RX_TIMEOUT_EN)
// PORTS
//  clk_100m        in   1   system clock
//  rst_n           in   1   reset
//  inr_rx          in   1   hdlcrev end-of-frame flag, clkr domain, level held >=2 clkr periods
//  rama            in   9   hdlcrev RAM write address; quasi-static while inr_rx high
//  emif_dpram_wen  in   1   EMIF write strobe, 1-cycle pulse
//  emif_dpram_ren  in   1   EMIF read strobe
//  emif_dpram_addr in   24  EMIF word address
//  emif_dpram_wdata in  16  EMIF write data
//  reg_rdata       out  16  register read data
//  reg_rsel        out  1   high when reg_rdata, not RAM data, must drive the EMIF bus
//  dsp_int         out  1   interrupt to DSP GPIO, active high
// BEHAVIOUR
//  Reset: rst_n is asynchronous, active-low; clock is clk_100m. All outputs reset to 0, FIFO empty, irq_en=1, overflow=0.
//  CDC: inr_rx passes through a 3-flop synchroniser. Rising edge of the synchronised signal -> eof pulse (1 cycle).
//  Capture: 2 cycles after eof, rama goes through a 2-flop register stage and is written as len[8:0] = rama.
//   Length is latched only if two consecutive samples are equal; otherwise it is resampled each cycle, for at most 8 cycles.
//   After 8 mismatching samples, the last sample is stored with err=1.
//  FIFO entry {err, len[8:0]}: 10 bits, circular, pointers wrap modulo FIFO_DEPTH, count of width clog2(DEPTH)+1.
//  Push when capture completes. If the FIFO is full, drop the frame and set sticky overflow.
//  Pop when the DSP writes BASE+2 (any data), FIFO non-empty. A pop while empty is ignored.
//  Simultaneous push+pop: both happen and count is unchanged. On a full FIFO, a simultaneous pop frees the slot, so the push succeeds and overflow is not set.
//  Registers (read):
//   BASE+0  STAT  {8'h0, overflow, irq_en, 1'b0, count[4:0]} (count zero-extended)
//   BASE+1  DESC  {valid, err, 4'h0, len[9:0]} of head; len zero-extended; 16'h0 when empty
//   Other addresses in the window read 16'h0.
//  Registers (write):
//   BASE+2  ACK   pop head
//   BASE+3  CTRL  bit0 = irq_en, bit1 = 1 clears overflow (self-clearing)
//  Read timing: reg_rdata and reg_rsel are registered, valid the cycle after emif_dpram_ren (1-cycle latency). reg_rsel is 0 otherwise.
//  IRQ FSM, 3 states:
//   IDLE -> PULSE on push with irq_en=1.
//   PULSE: dsp_int=1 for exactly IRQ_WIDTH cycles, then -> WAIT.
//   WAIT -> IDLE when the FIFO is empty.
//   WAIT -> PULSE on a new push (one pulse per frame; pushes during PULSE are not re-pulsed).
//  irq_en=0 forces the FSM to IDLE and dsp_int=0 on the next cycle. FIFO contents are unaffected.
//  Reset mid-frame or mid-pulse: everything returns to reset values immediately, and the queued descriptors are lost.
// CONFIGURATION
//  HDLC_RX_TIMEOUT_EN defined: a 17-bit counter runs in WAIT while the FIFO is non-empty.
//   When it reaches TIMEOUT_CYC the FSM -> PULSE (re-interrupt) and the counter resets.
//   The counter also resets on any pop or CTRL write.
//  HDLC_RX_TIMEOUT_EN undefined: no counter. WAIT leaves only on empty or a push.
// TESTING
//  1 Single frame: inr_rx high, rama=9'd37 -> DESC=16'h8025 and STAT count=1.
//    dsp_int high for 50 cycles, starting <=6 cycles after inr_rx edge plus capture.
//  2 Fill/overflow: 5 frames without ACK, lengths 1..5 -> count=4 and overflow=1.
//    Then 4 ACKs -> DESC reads len 1,2,3,4, then 16'h0.
//  3 Push+pop same cycle with FIFO full -> count stays 4 and overflow stays 0.
//  4 irq_en cleared via CTRL=16'h0000 during a pulse -> dsp_int=0 next cycle.
//    The frame stays queued; CTRL=16'h0003 clears overflow.
//  5 rama toggling 10'h055/0AA for 10 cycles during capture -> entry err=1, DESC bit14=1.
//  6 With HDLC_RX_TIMEOUT_EN and TIMEOUT_CYC=1000: a frame left un-acked -> second dsp_int pulse 1000 cycles after WAIT entry.
//    ACK -> no further pulses. Without the macro, no second pulse.

Source files
------------

// File: rtl/hdlc_rx_desc_ctrl.sv
// hdlc_rx_desc_ctrl
//   Receive-side descriptor controller that sits downstream of hdlcrev.
//   - Synchronises the hdlcrev end-of-frame flag into clk_100m.
//   - Captures the frame length from the RAM write address and checks that
//     it is stable.
//   - Queues one {err, len} descriptor per frame.
//   - Pulses a DSP interrupt line for each frame.
//   - Exposes status, descriptor, ack and control registers on the EMIF bus.
//
// Ports
//   clk_100m          system clock
//   rst_n             asynchronous active-low reset
//   inr_rx            hdlcrev end-of-frame level (clkr domain)
//   rama[8:0]         hdlcrev RAM write address, quasi-static while inr_rx high
//   emif_dpram_wen    EMIF write strobe (1-cycle)
//   emif_dpram_ren    EMIF read strobe
//   emif_dpram_addr   EMIF word address
//   emif_dpram_wdata  EMIF write data
//   reg_rdata         register read data, 1 cycle after emif_dpram_ren
//   reg_rsel          high when reg_rdata must drive the EMIF bus
//   dsp_int           DSP interrupt (GPIO), active high
//
// Register window (word addresses relative to REG_BASE)
//   +0 STAT  R  {8'h0, overflow, irq_en, 1'b0, count[4:0]}
//   +1 DESC  R  {valid, err, 4'h0, 1'b0, len[8:0]} of the FIFO head, 0 when empty
//   +2 ACK   W  pop the FIFO head
//   +3 CTRL  W  bit0 irq_en, bit1 = 1 clears overflow
//
// Optional feature: define HDLC_RX_TIMEOUT_EN to re-interrupt the DSP every
// TIMEOUT_CYC cycles while descriptors remain un-acked.
//
// IRQ FSM
//   state     | meaning
//   IRQ_IDLE  | nothing pending to signal
//   IRQ_PULSE | dsp_int high, counting down IRQ_WIDTH cycles
//   IRQ_WAIT  | pulse sent, waiting for the DSP to drain the FIFO
`timescale 1ns/1ps

module hdlc_rx_desc_ctrl #(
  parameter logic [23:0] REG_BASE    = 24'h000100,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          IRQ_WIDTH   = 50,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        inr_rx,
  input  logic [8:0]  rama,
  input  logic        emif_dpram_wen,
  input  logic        emif_dpram_ren,
  input  logic [23:0] emif_dpram_addr,
  input  logic [15:0] emif_dpram_wdata,
  output logic [15:0] reg_rdata,
  output logic        reg_rsel,
  output logic        dsp_int
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [16:0] TMO_RELOAD = 17'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IRQ_IDLE, IRQ_PULSE, IRQ_WAIT} irq_state_t;

  irq_state_t state, state_nxt;

  // Three synchroniser flops plus one history flop for edge detection.
  logic [3:0] sync_q;
  logic       eof;
  logic [8:0] rama_q1, rama_q2;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      rama_q1 <= '0;
      rama_q2 <= '0;
    end else begin
      sync_q  <= {sync_q[2:0], inr_rx};
      rama_q1 <= rama;
      rama_q2 <= rama_q1;
    end
  end

  assign eof = sync_q[2] & ~sync_q[3];

  // Length capture: wait two cycles, then sample until two consecutive
  // samples agree; after eight disagreements keep the last one and flag err.
  logic       cap_busy, cap_first, cap_done, cap_err;
  logic [1:0] cap_dly;
  logic [2:0] cap_miss;
  logic [8:0] cap_prev, cap_len;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      cap_busy  <= 1'b0;
      cap_first <= 1'b0;
      cap_done  <= 1'b0;
      cap_err   <= 1'b0;
      cap_dly   <= '0;
      cap_miss  <= '0;
      cap_prev  <= '0;
      cap_len   <= '0;
    end else begin
      cap_done <= 1'b0;
      if (eof) begin
        cap_busy  <= 1'b1;
        cap_first <= 1'b1;
        cap_dly   <= 2'd2;
        cap_miss  <= '0;
      end else if (cap_busy) begin
        if (cap_dly != 2'd0) begin
          cap_dly <= cap_dly - 2'd1;
        end else begin
          cap_prev  <= rama_q2;
          cap_first <= 1'b0;
          if (!cap_first) begin
            if (rama_q2 == cap_prev) begin
              cap_done <= 1'b1;
              cap_err  <= 1'b0;
              cap_len  <= rama_q2;
              cap_busy <= 1'b0;
            end else if (cap_miss == 3'd7) begin
              cap_done <= 1'b1;
              cap_err  <= 1'b1;
              cap_len  <= rama_q2;
              cap_busy <= 1'b0;
            end else begin
              cap_miss <= cap_miss + 3'd1;
            end
          end
        end
      end
    end
  end

  // Register window decode.
  logic [23:0] reg_off;
  logic        in_win, wr_ack, wr_ctrl;

  assign reg_off = emif_dpram_addr - REG_BASE;
  assign in_win  = (reg_off < 24'd4);
  assign wr_ack  = emif_dpram_wen & in_win & (reg_off[1:0] == 2'd2);
  assign wr_ctrl = emif_dpram_wen & in_win & (reg_off[1:0] == 2'd3);

  // Descriptor FIFO. A pop in the same cycle frees a slot for a push on full.
  logic [9:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             fifo_full, fifo_empty, pop_req, push_ok, drop;
  logic [9:0]       head;

  assign fifo_full  = (cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt == '0);
  assign pop_req    = wr_ack & ~fifo_empty;
  assign push_ok    = cap_done & (~fifo_full | pop_req);
  assign drop       = cap_done & fifo_full & ~pop_req;
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk_100m) begin
    if (push_ok) fifo_mem[wr_ptr] <= {cap_err, cap_len};
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_req) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_req)      cnt <= cnt + 1'b1;
      else if (pop_req && !push_ok) cnt <= cnt - 1'b1;
    end
  end

  // Control state. irq_en_nxt lets a CTRL write take effect on the FSM in
  // the same cycle, so dsp_int drops the cycle after the write.
  logic irq_en, irq_en_nxt, overflow;

  assign irq_en_nxt = wr_ctrl ? emif_dpram_wdata[0] : irq_en;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      irq_en   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      irq_en <= irq_en_nxt;
      if (drop)                                 overflow <= 1'b1;
      else if (wr_ctrl && emif_dpram_wdata[1]) overflow <= 1'b0;
    end
  end

  // Registered read path.
  logic [15:0] rd_mux;

  always_comb begin
    rd_mux = 16'h0;
    case (reg_off[1:0])
      2'd0:    rd_mux = {8'h0, overflow, irq_en, 1'b0, 5'(cnt)};
      2'd1:    rd_mux = fifo_empty ? 16'h0 : {1'b1, head[9], 4'h0, 1'b0, head[8:0]};
      default: rd_mux = 16'h0;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      reg_rdata <= '0;
      reg_rsel  <= 1'b0;
    end else if (emif_dpram_ren && in_win) begin
      reg_rdata <= rd_mux;
      reg_rsel  <= 1'b1;
    end else begin
      reg_rdata <= '0;
      reg_rsel  <= 1'b0;
    end
  end

  // Re-interrupt timer.
  logic tmo_fire;

`ifdef HDLC_RX_TIMEOUT_EN
  logic [16:0] tmo_cnt;
  logic        tmo_run;

  assign tmo_run  = (state == IRQ_WAIT) & ~fifo_empty & ~pop_req & ~wr_ctrl;
  assign tmo_fire = tmo_run & (tmo_cnt == 17'd0);

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)                  tmo_cnt <= TMO_RELOAD;
    else if (!tmo_run)           tmo_cnt <= TMO_RELOAD;
    else if (tmo_cnt == 17'd0)   tmo_cnt <= TMO_RELOAD;
    else                         tmo_cnt <= tmo_cnt - 17'd1;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = |TMO_RELOAD;
  assign tmo_fire       = 1'b0;
`endif

  // IRQ FSM with pulse-width down-counter.
  logic [7:0] pulse_cnt;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IRQ_IDLE;
      pulse_cnt <= 8'(IRQ_WIDTH - 1);
    end else begin
      state <= state_nxt;
      if (state != IRQ_PULSE)    pulse_cnt <= 8'(IRQ_WIDTH - 1);
      else if (pulse_cnt != 8'd0) pulse_cnt <= pulse_cnt - 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IRQ_IDLE:  if (push_ok) state_nxt = IRQ_PULSE;
      IRQ_PULSE: if (pulse_cnt == 8'd0) state_nxt = IRQ_WAIT;
      IRQ_WAIT: begin
        if (push_ok || tmo_fire) state_nxt = IRQ_PULSE;
        else if (fifo_empty)     state_nxt = IRQ_IDLE;
      end
      default:   state_nxt = IRQ_IDLE;
    endcase
    if (!irq_en_nxt) state_nxt = IRQ_IDLE;
  end

  assign dsp_int = (state == IRQ_PULSE);

  logic unused_wdata;
  assign unused_wdata = ^emif_dpram_wdata[15:2];

endmodule

// File: tb/tb_hdlc_rx_desc_ctrl.sv
`timescale 1ns/1ps

module tb_hdlc_rx_desc_ctrl;

  localparam logic [23:0] BASE = 24'h000100;
  localparam int          TMO  = 1000;

  logic        clk_100m = 1'b0;
  logic        rst_n = 1'b0;
  logic        inr_rx = 1'b0;
  logic [8:0]  rama = '0;
  logic        emif_dpram_wen = 1'b0;
  logic        emif_dpram_ren = 1'b0;
  logic [23:0] emif_dpram_addr = '0;
  logic [15:0] emif_dpram_wdata = '0;
  logic [15:0] reg_rdata;
  logic        reg_rsel;
  logic        dsp_int;

  hdlc_rx_desc_ctrl #(
    .REG_BASE(BASE), .FIFO_DEPTH(4), .IRQ_WIDTH(50), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .inr_rx(inr_rx), .rama(rama),
    .emif_dpram_wen(emif_dpram_wen), .emif_dpram_ren(emif_dpram_ren),
    .emif_dpram_addr(emif_dpram_addr), .emif_dpram_wdata(emif_dpram_wdata),
    .reg_rdata(reg_rdata), .reg_rsel(reg_rsel), .dsp_int(dsp_int)
  );

  always #5 clk_100m = ~clk_100m;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  bit          model_ovf = 1'b0;

  typedef struct {
    logic [8:0]  len;
    logic [15:0] exp_stat;
  } vec_t;

  vec_t tv[5];

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reg_read(input logic [23:0] a, output logic [15:0] d, output logic s);
    emif_dpram_addr = a;
    emif_dpram_ren  = 1'b1;
    tick();
    emif_dpram_ren  = 1'b0;
    d = reg_rdata;
    s = reg_rsel;
  endtask

  task automatic reg_write(input logic [23:0] a, input logic [15:0] d);
    emif_dpram_addr  = a;
    emif_dpram_wdata = d;
    emif_dpram_wen   = 1'b1;
    tick();
    emif_dpram_wen   = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [23:0] a, input logic [15:0] e);
    logic [15:0] d;
    logic        s;
    reg_read(a, d, s);
    check(name, {15'h0, s, d}, {15'h0, 1'b1, e});
  endtask

  // Reference FIFO: depth 4, optional same-cycle pop, sticky overflow.
  task automatic model_push(input logic [8:0] len, input bit popped);
    if (popped && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_q.size() < 4) exp_q.push_back({1'b1, 1'b0, 4'h0, 1'b0, len});
    else                  model_ovf = 1'b1;
  endtask

  task automatic frame_start(input logic [8:0] len);
    rama   = len;
    inr_rx = 1'b1;
  endtask

  task automatic frame_end();
    inr_rx = 1'b0;
    repeat (6) tick();
  endtask

  // The descriptor is pushed on the 9th edge after inr_rx rises; with ack=1
  // the ACK strobe is placed on exactly that edge.
  task automatic send_frame(input logic [8:0] len, input bit ack);
    frame_start(len);
    model_push(len, ack);
    repeat (8) tick();
    if (ack) reg_write(BASE + 24'd2, 16'h0);
    else     tick();
    repeat (4) tick();
    frame_end();
  endtask

  task automatic drain(input string name);
    logic [15:0] e;
    for (int n = 0; n < 8 && exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      check_reg(name, BASE + 24'd1, e);
      reg_write(BASE + 24'd2, 16'h0);
    end
    check_reg({name, "_empty"}, BASE + 24'd1, 16'h0);
  endtask

  task automatic wait_rise(input int max, output int k);
    k = 0;
    while (dsp_int !== 1'b1 && k < max) begin
      tick();
      k++;
    end
  endtask

  task automatic pulse_width(output int w);
    w = 0;
    while (dsp_int === 1'b1 && w < 200) begin
      w++;
      tick();
    end
  endtask

  initial begin
    logic [15:0] d;
    logic        s;
    int          k, w;

    tv[0] = '{9'd1, 16'h0041};
    tv[1] = '{9'd2, 16'h0042};
    tv[2] = '{9'd3, 16'h0043};
    tv[3] = '{9'd4, 16'h0044};
    tv[4] = '{9'd5, 16'h00C4};

    // Reset state
    repeat (3) tick();
    check("reset_outputs", {14'h0, dsp_int, reg_rsel, reg_rdata}, 32'h0);
    rst_n = 1'b1;
    tick();
    check_reg("stat_reset", BASE, 16'h0040);
    check_reg("desc_reset", BASE + 24'd1, 16'h0);
    check_reg("read_ack_addr", BASE + 24'd2, 16'h0);
    reg_read(BASE + 24'd4, d, s);
    check("read_outside_window", {15'h0, s, d}, 32'h0);
    check("rsel_idle", {31'h0, reg_rsel}, 32'h0);

    // Single frame
    frame_start(9'd37);
    model_push(9'd37, 1'b0);
    wait_rise(20, k);
    check("irq_rise_latency_ok", 32'(k <= 12), 32'd1);
    pulse_width(w);
    check("irq_width", 32'(w), 32'd50);
    frame_end();
    check_reg("stat_single", BASE, 16'h0041);
    drain("desc_single");

    // Fill and overflow, table driven
    repeat (60) tick();
    for (int i = 0; i < 5; i++) begin
      send_frame(tv[i].len, 1'b0);
      check_reg($sformatf("stat_fill_%0d", i), BASE, tv[i].exp_stat);
    end
    drain("desc_fill");
    check_reg("stat_after_drain", BASE, {8'h0, model_ovf, 1'b1, 1'b0, 5'd0});

    // irq_en cleared mid-pulse, then overflow clear
    repeat (60) tick();
    frame_start(9'd100);
    model_push(9'd100, 1'b0);
    wait_rise(20, k);
    check("irq4_rise_ok", 32'(k <= 12), 32'd1);
    repeat (5) tick();
    reg_write(BASE + 24'd3, 16'h0000);
    check("irq_off_next_cycle", {31'h0, dsp_int}, 32'h0);
    frame_end();
    check_reg("stat_irq_off", BASE, 16'h0081);
    reg_write(BASE + 24'd3, 16'h0003);
    model_ovf = 1'b0;
    check_reg("stat_ovf_clear", BASE, 16'h0041);
    drain("desc_irq_off");

    // Push and pop in the same cycle on a full FIFO
    for (int i = 0; i < 4; i++) send_frame(9'(10 + i), 1'b0);
    check_reg("stat_full", BASE, 16'h0044);
    send_frame(9'd14, 1'b1);
    check_reg("stat_push_pop_full", BASE, 16'h0044);
    drain("desc_push_pop");

    // Unstable length -> err flag
    inr_rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rama = i[0] ? 9'h0AA : 9'h055;
      tick();
    end
    frame_end();
    reg_read(BASE + 24'd1, d, s);
    check("desc_err_flags", {16'h0, d[15:9]}, {16'h0, 7'b1100000});
    check("desc_err_len_is_sample", 32'(d[8:0] == 9'h055 || d[8:0] == 9'h0AA), 32'd1);
    reg_write(BASE + 24'd2, 16'h0);
    check_reg("stat_err_acked", BASE, 16'h0040);

    // Un-acked frame: re-interrupt only with the timeout feature
    repeat (60) tick();
    frame_start(9'd200);
    model_push(9'd200, 1'b0);
    wait_rise(20, k);
    inr_rx = 1'b0;
    pulse_width(w);
    check("irq6_width", 32'(w), 32'd50);
    wait_rise(1100, k);
`ifdef HDLC_RX_TIMEOUT_EN
    check("timeout_repulse_delay", 32'(k), 32'(TMO));
    reg_write(BASE + 24'd2, 16'h0);
    void'(exp_q.pop_front());
    pulse_width(w);
    wait_rise(1100, k);
    check("no_pulse_after_ack", 32'(k), 32'd1100);
`else
    check("no_repulse", 32'(k), 32'd1100);
    reg_write(BASE + 24'd2, 16'h0);
    void'(exp_q.pop_front());
`endif
    check_reg("stat_timeout_end", BASE, 16'h0040);

    // Reset mid-pulse with a queued descriptor
    repeat (60) tick();
    frame_start(9'd55);
    wait_rise(20, k);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_pulse_irq", {31'h0, dsp_int}, 32'h0);
    inr_rx = 1'b0;
    rama   = '0;
    #10;
    rst_n = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
    tick();
    check_reg("stat_after_reset", BASE, 16'h0040);
    check_reg("desc_after_reset", BASE + 24'd1, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
